// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants, pixel/address types and colour helper shared by the scan-out
package vga_pkg;

  localparam int H_TOTAL  = 640 + 16 + 96 + 48;
  localparam int V_TOTAL  = 480 + 10 + 2 + 33;
  localparam int WIN_SIZE = 256;

  typedef logic [9:0] cnt_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_px_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } win_addr_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic win;
    logic border;
  } px_tag_t;

  function automatic vga_px_t to_px(rgb24_t c);
    return '{r: c.r[7:4], g: c.g[7:4], b: c.b[7:4]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v scan counters, raw syncs, active flag and registered vblank/frame_start
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk,
  input  logic rst,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic hs_raw,
  output logic vs_raw,
  output logic active,
  output logic vblank,
  output logic frame_start
);

  localparam cnt_t HA  = cnt_t'(H_ACTIVE);
  localparam cnt_t HS0 = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS1 = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t HL  = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t VA  = cnt_t'(V_ACTIVE);
  localparam cnt_t VS0 = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS1 = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t VL  = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  cnt_t h_d, h_q, v_d, v_q;
  logic vblank_d, vblank_q, fs_d, fs_q;

  // next scan position; vblank/frame_start are computed from it so the registered flags line up with the counters
  always_comb begin
    h_d      = (h_q == HL) ? '0 : h_q + cnt_t'(1);
    v_d      = (h_q != HL) ? v_q : (v_q == VL) ? '0 : v_q + cnt_t'(1);
    vblank_d = v_d >= VA;
    fs_d     = h_d == '0 && v_d == VA;
  end

  // scan state, cleared to the top-left corner on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q      <= '0;
      v_q      <= '0;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      vblank_q <= vblank_d;
      fs_q     <= fs_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign hs_raw      = !(h_q >= HS0 && h_q < HS1);
  assign vs_raw      = !(v_q >= VS0 && v_q < VS1);
  assign active      = h_q < HA && v_q < VA;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA scan-out of a centred 256x256 image from a synchronous pixel memory; VGA_SCANOUT_BORDER_EN draws a white 1-pixel ring around the image
module vga_scanout import vga_pkg::*; #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          WIN_X0   = 192,
  parameter int          WIN_Y0   = 112,
  parameter int          RD_LAT   = 1,
  parameter logic [23:0] BG_RGB   = 24'h202020
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [23:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank,
  output logic        frame_start
);

  localparam cnt_t WX0 = cnt_t'(WIN_X0);
  localparam cnt_t WX1 = cnt_t'(WIN_X0 + WIN_SIZE - 1);
  localparam cnt_t WY0 = cnt_t'(WIN_Y0);
  localparam cnt_t WY1 = cnt_t'(WIN_Y0 + WIN_SIZE - 1);
`ifdef VGA_SCANOUT_BORDER_EN
  localparam cnt_t BX0 = cnt_t'(WIN_X0 - 1);
  localparam cnt_t BX1 = cnt_t'(WIN_X0 + WIN_SIZE);
  localparam cnt_t BY0 = cnt_t'(WIN_Y0 - 1);
  localparam cnt_t BY1 = cnt_t'(WIN_Y0 + WIN_SIZE);
`endif
  localparam px_tag_t TAG_BLANK = '{hs: 1'b1, vs: 1'b1, default: 1'b0};
  localparam vga_px_t PX_BG     = to_px(BG_RGB);
  localparam vga_px_t PX_WHITE  = '1;

  cnt_t      h_cnt, v_cnt;
  logic      hs_raw, vs_raw, active;
  px_tag_t   tag, last;
  win_addr_t addr;
  px_tag_t [RD_LAT-1:0] pipe_d, pipe_q;
  vga_px_t   px_d, px_q;
  logic      hs_d, hs_q, vs_d, vs_q;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .active      (active),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  // classify the pixel under the counters and form its image address (zero outside the window)
  always_comb begin
    tag        = TAG_BLANK;
    tag.hs     = hs_raw;
    tag.vs     = vs_raw;
    tag.active = active;
    tag.win    = h_cnt >= WX0 && h_cnt <= WX1 && v_cnt >= WY0 && v_cnt <= WY1;
`ifdef VGA_SCANOUT_BORDER_EN
    tag.border = ((h_cnt == BX0 || h_cnt == BX1) && v_cnt >= BY0 && v_cnt <= BY1) ||
                 ((v_cnt == BY0 || v_cnt == BY1) && h_cnt >= BX0 && h_cnt <= BX1);
`else
    tag.border = 1'b0;
`endif
    addr.x     = tag.win ? 8'(h_cnt - WX0) : '0;
    addr.y     = tag.win ? 8'(v_cnt - WY0) : '0;
  end

  assign rd_en   = tag.win;
  assign rd_addr = addr;
  assign last    = pipe_q[RD_LAT-1];

  // delay the tags by the memory latency so the oldest one meets its rd_data, then choose the colour
  always_comb begin
    pipe_d[0] = tag;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    px_d = last.win ? to_px(rd_data) : last.border ? PX_WHITE : last.active ? PX_BG : '0;
    hs_d = last.hs;
    vs_d = last.vs;
  end

  // tag pipeline and pin registers; reset leaves the screen blank with syncs idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= {RD_LAT{TAG_BLANK}};
      px_q   <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      pipe_q <= pipe_d;
      px_q   <= px_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign vga_r  = px_q.r;
  assign vga_g  = px_q.g;
  assign vga_b  = px_q.b;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: five scan-out instances (spec timing, three shrunken-timing latencies, a tiny multi-frame one) checked every cycle against an arithmetic screen model
module tb_vga_scanout;

  localparam int N = 5;
  localparam int P_HA  [N] = '{640, 260, 260, 260, 16};
  localparam int P_HFP [N] = '{16,  2,   2,   2,   2};
  localparam int P_HS  [N] = '{96,  4,   4,   4,   3};
  localparam int P_HBP [N] = '{48,  2,   2,   2,   3};
  localparam int P_VA  [N] = '{480, 259, 259, 259, 8};
  localparam int P_VFP [N] = '{10,  1,   1,   1,   1};
  localparam int P_VS  [N] = '{2,   2,   2,   2,   2};
  localparam int P_VBP [N] = '{33,  1,   1,   1,   1};
  localparam int P_WX  [N] = '{192, 2,   2,   2,   600};
  localparam int P_WY  [N] = '{112, 1,   1,   1,   600};
  localparam int P_LAT [N] = '{1,   1,   2,   3,   2};

  logic        clk, rst;
  logic        en   [N];
  logic [15:0] addr [N];
  logic [3:0]  r [N], g [N], b [N];
  logic        hs [N], vs [N], vb [N], fs [N];
  logic [23:0] dq [N][3];
  logic [7:0]  bmem [65536];
  int          k, vectors, miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar d = 0; d < N; d++) begin : g_dut
    vga_scanout #(
      .H_ACTIVE (P_HA[d]),  .H_FP (P_HFP[d]), .H_SYNC (P_HS[d]), .H_BP (P_HBP[d]),
      .V_ACTIVE (P_VA[d]),  .V_FP (P_VFP[d]), .V_SYNC (P_VS[d]), .V_BP (P_VBP[d]),
      .WIN_X0   (P_WX[d]),  .WIN_Y0 (P_WY[d]), .RD_LAT (P_LAT[d]), .BG_RGB (24'h202020)
    ) u_dut (
      .clk (clk), .rst (rst), .rd_en (en[d]), .rd_addr (addr[d]),
      .rd_data (dq[d][P_LAT[d]-1]),
      .vga_r (r[d]), .vga_g (g[d]), .vga_b (b[d]), .vga_hs (hs[d]), .vga_vs (vs[d]),
      .vblank (vb[d]), .frame_start (fs[d])
    );
  end

  function automatic logic [23:0] memf(logic [15:0] a);
    return {a[15:8], a[7:0], bmem[a]};
  endfunction

  // pixel memory: word is {X, Y, random byte}, returned RD_LAT cycles after the address
  always @(posedge clk)
    for (int i = 0; i < N; i++) begin
      dq[i][0] <= memf(addr[i]);
      dq[i][1] <= dq[i][0];
      dq[i][2] <= dq[i][1];
    end

  function automatic bit in_win(int h, int v, int wx, int wy);
    return h >= wx && h < wx + 256 && v >= wy && v < wy + 256;
  endfunction

  function automatic bit in_ring(int h, int v, int wx, int wy);
    return ((h == wx - 1 || h == wx + 256) && v >= wy - 1 && v <= wy + 256) ||
           ((v == wy - 1 || v == wy + 256) && h >= wx - 1 && h <= wx + 256);
  endfunction

  // expected {rd_en, rd_addr, r, g, b, hs, vs, vblank, frame_start} for instance i, k cycles after reset release
  function automatic logic [32:0] expect_vec(int i, int kk);
    int ht, vt, h, v, n, ph, pv, wx, wy;
    logic        e, hsx, vsx;
    logic [15:0] a;
    logic [11:0] px;
    logic [7:0]  x, y, bb;
    ht = P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
    vt = P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
    wx = P_WX[i];
    wy = P_WY[i];
    h  = kk % ht;
    v  = (kk / ht) % vt;
    e  = in_win(h, v, wx, wy);
    a  = e ? {8'(h - wx), 8'(v - wy)} : 16'h0000;
    hsx = 1'b1;
    vsx = 1'b1;
    px  = 12'h000;
    if (kk >= P_LAT[i] + 1) begin
      n   = kk - P_LAT[i] - 1;
      ph  = n % ht;
      pv  = (n / ht) % vt;
      hsx = !(ph >= P_HA[i] + P_HFP[i] && ph < P_HA[i] + P_HFP[i] + P_HS[i]);
      vsx = !(pv >= P_VA[i] + P_VFP[i] && pv < P_VA[i] + P_VFP[i] + P_VS[i]);
      if (in_win(ph, pv, wx, wy)) begin
        x  = 8'(ph - wx);
        y  = 8'(pv - wy);
        bb = bmem[{x, y}];
        px = {x[7:4], y[7:4], bb[7:4]};
      end
`ifdef VGA_SCANOUT_BORDER_EN
      else if (in_ring(ph, pv, wx, wy)) px = 12'hFFF;
`endif
      else if (ph < P_HA[i] && pv < P_VA[i]) px = 12'h222;
    end
    return {e, a, px, hsx, vsx, v >= P_VA[i], h == 0 && v == P_VA[i]};
  endfunction

  task automatic check_all();
    logic [32:0] obs, exp;
    for (int i = 0; i < N; i++) begin
      exp = expect_vec(i, k);
      obs = {en[i], addr[i], r[i], g[i], b[i], hs[i], vs[i], vb[i], fs[i]};
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL pins[%0d] k=%0d observed=%h expected=%h", i, k, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) k++;
    #1;
    check_all();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    k           = 0;
    for (int i = 0; i < 65536; i++) bmem[i] = 8'($urandom);
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat ($urandom_range(300, 3000)) tick();
    rst = 1'b0;
    k   = 0;
    #1 check_all();
    repeat (3) tick();
    rst = 1'b1;
    repeat (70300) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
